// File: rtl/irq_ack_dispatcher.sv
// Interrupt dispatcher: captures device request edges into pending bits and feeds them to an external
// priority encoder. It then runs the CPU irq / ack / vector / eoi handshake for the winner the encoder reports.
module irq_ack_dispatcher #(
  parameter int unsigned NCH      = 9,
  parameter int unsigned NBUS     = 3,
  parameter logic [7:0]  VEC_BASE = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBUS*NCH-1:0]  dev_req,
  output logic [NBUS*NCH-1:0]  dev_ack,
  input  logic                 mask_we,
  input  logic [NCH-1:0]       mask_wdata,
  output logic [NBUS*NCH-1:0]  pend_o,
  output logic [NCH-1:0]       en_o,
  input  logic [NBUS-1:0]      grant_bus,
  input  logic [3:0]           grant_chan,
  output logic                 irq_o,
  input  logic                 cpu_ack,
  output logic [7:0]           vec_o,
  output logic                 vec_valid,
  input  logic                 eoi,
  output logic                 err_o
);

  localparam int unsigned NREQ = NBUS * NCH;
  localparam int unsigned BW   = (NBUS > 1) ? $clog2(NBUS) : 1;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, SERV} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] prev_req_q, pend_q, pend_d;
  logic [NCH-1:0]  en_q, en_d;
  logic [BW-1:0]   cur_bus_q, cur_bus_d, win_bus;
  logic [3:0]      cur_chan_q, cur_chan_d;
  logic [7:0]      vec_q, vec_d;
  logic            err_q, err_d;
  logic            grant_any, chan_ok;
  logic [IW-1:0]   ack_idx;

  assign grant_any = |grant_bus;
  assign chan_ok   = grant_chan < 4'(NCH);
  assign ack_idx   = IW'(cur_bus_q) * IW'(NCH) + IW'(cur_chan_q);

  // Lowest-index bus flag wins.
  always_comb begin
    win_bus = '0;
    for (int unsigned i = NBUS; i > 0; i--) begin
      if (grant_bus[i-1]) win_bus = BW'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any && chan_ok) state_d = REQ;
      REQ:     if (cpu_ack) state_d = ACK;
      ACK:     state_d = SERV;
      SERV:    if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_o     = 1'b0;
    vec_valid = 1'b0;
    dev_ack   = '0;
    case (state_q)
      REQ:  irq_o = 1'b1;
      ACK: begin
        vec_valid = 1'b1;
        dev_ack   = {{(NREQ-1){1'b0}}, 1'b1} << ack_idx;
      end
      SERV: vec_valid = 1'b1;
      default: ;
    endcase
  end

  // A fresh edge on the bit being acknowledged re-arms it rather than being lost.
  always_comb begin
    pend_d     = (pend_q & ~dev_ack) | (dev_req & ~prev_req_q);
    en_d       = mask_we ? mask_wdata : en_q;
    cur_bus_d  = cur_bus_q;
    cur_chan_d = cur_chan_q;
    vec_d      = vec_q;
    err_d      = err_q;
    if (state_q == IDLE && grant_any) begin
      if (chan_ok) begin
        cur_bus_d  = win_bus;
        cur_chan_d = grant_chan;
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == REQ && cpu_ack)
      vec_d = VEC_BASE + 8'(cur_bus_q) * 8'(NCH) + 8'(cur_chan_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_req_q <= '0;
      pend_q     <= '0;
      en_q       <= '1;
      cur_bus_q  <= '0;
      cur_chan_q <= '0;
      vec_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_req_q <= dev_req;
      pend_q     <= pend_d;
      en_q       <= en_d;
      cur_bus_q  <= cur_bus_d;
      cur_chan_q <= cur_chan_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
    end
  end

  assign pend_o = pend_q;
  assign en_o   = en_q;
  assign vec_o  = vec_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_irq_ack_dispatcher.sv
// Bench for irq_ack_dispatcher: a behavioural encoder closes the loop, and expected acks/vectors are queued
// and matched by a monitor whenever dev_ack pulses.
module tb_irq_ack_dispatcher;
  localparam int unsigned NCH  = 9;
  localparam int unsigned NBUS = 3;
  localparam int unsigned NREQ = NBUS * NCH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] dev_req, dev_ack, pend_o;
  logic            mask_we;
  logic [NCH-1:0]  mask_wdata, en_o;
  logic [NBUS-1:0] grant_bus;
  logic [3:0]      grant_chan;
  logic            irq_o, cpu_ack, vec_valid, eoi, err_o;
  logic [7:0]      vec_o;
  logic            force_err;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [7:0]      vec;
  } exp_t;
  exp_t exp_q[$];

  irq_ack_dispatcher #(.NCH(NCH), .NBUS(NBUS), .VEC_BASE(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .dev_req(dev_req), .dev_ack(dev_ack),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .pend_o(pend_o), .en_o(en_o),
    .grant_bus(grant_bus), .grant_chan(grant_chan), .irq_o(irq_o), .cpu_ack(cpu_ack),
    .vec_o(vec_o), .vec_valid(vec_valid), .eoi(eoi), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference encoder: lowest bus with an enabled pending bit, lowest channel within it.
  logic [NREQ-1:0] masked;
  logic [NCH-1:0]  seg, sh;
  logic            found;
  always_comb begin
    masked     = pend_o & {NBUS{en_o}};
    grant_bus  = '0;
    grant_chan = '0;
    found      = 1'b0;
    seg        = '0;
    sh         = '0;
    for (int b = 0; b < NBUS; b++) begin
      seg = NCH'(masked >> (b * NCH));
      if (seg != '0) grant_bus = grant_bus | (NBUS'(1) << b);
      for (int c = 0; c < NCH; c++) begin
        sh = seg >> c;
        if (sh[0] && !found) begin
          found      = 1'b1;
          grant_chan = 4'(c);
        end
      end
    end
    if (force_err) begin
      grant_bus  = 3'b001;
      grant_chan = 4'd12;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dev_ack != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got %0h, expected none", dev_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dev_ack", 32'(dev_ack), 32'(e.ack));
        chk("vec_o", 32'(vec_o), 32'(e.vec));
        chk("vec_valid_at_ack", 32'(vec_valid), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (!irq_o && n < budget) begin
      tick();
      n++;
    end
    chk("irq_wait", 32'(irq_o), 32'd1);
  endtask

  // Runs the handshake up to the first SERV cycle; req_in_ack is ORed onto dev_req during the ACK cycle.
  task automatic to_serv(input int idx, input logic [7:0] vec, input logic [NREQ-1:0] req_in_ack);
    exp_t e;
    wait_irq(8);
    e.ack = NREQ'(1) << idx;
    e.vec = vec;
    exp_q.push_back(e);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    dev_req = dev_req | req_in_ack;
    chk("irq_in_ack", 32'(irq_o), 32'd0);
    chk("vv_in_ack", 32'(vec_valid), 32'd1);
    tick();
    chk("ack_one_cycle", 32'(dev_ack), 32'd0);
    chk("vv_in_serv", 32'(vec_valid), 32'd1);
  endtask

  task automatic finish_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("vv_after_eoi", 32'(vec_valid), 32'd0);
    chk("irq_after_eoi", 32'(irq_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dev_req = '0; mask_we = 1'b0; mask_wdata = '0;
    cpu_ack = 1'b0; eoi = 1'b0; force_err = 1'b0;
    tick(); tick(); tick();
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_vv", 32'(vec_valid), 32'd0);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_en", 32'(en_o), 32'h1FF);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_vec", 32'(vec_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request bus1/chan4 with exact latency.
    dev_req[13] = 1'b1;
    tick();
    chk("pend13", 32'(pend_o), 32'h2000);
    chk("irq_t1", 32'(irq_o), 32'd0);
    tick();
    chk("irq_t2", 32'(irq_o), 32'd1);
    to_serv(13, 8'h2D, '0);
    chk("pend13_clr", 32'(pend_o), 32'd0);
    finish_eoi();
    dev_req = '0;
    tick();

    // Two simultaneous requests: bus0/chan2 before bus2/chan0.
    dev_req[2] = 1'b1; dev_req[18] = 1'b1;
    tick();
    chk("pend_2_18", 32'(pend_o), 32'h40004);
    to_serv(2, 8'h22, '0);
    finish_eoi();
    to_serv(18, 8'h32, '0);
    finish_eoi();
    chk("pend_after_pair", 32'(pend_o), 32'd0);
    dev_req = '0;
    tick();

    // Masked channel stays pending without raising irq.
    mask_we = 1'b1; mask_wdata = 9'h1FB;
    tick();
    mask_we = 1'b0;
    chk("en_masked", 32'(en_o), 32'h1FB);
    dev_req[2] = 1'b1;
    tick(); tick(); tick();
    chk("pend2_masked", 32'(pend_o), 32'h4);
    chk("irq_masked", 32'(irq_o), 32'd0);
    mask_we = 1'b1; mask_wdata = 9'h1FF;
    tick();
    mask_we = 1'b0;
    chk("en_unmasked", 32'(en_o), 32'h1FF);
    to_serv(2, 8'h22, '0);
    finish_eoi();
    dev_req = '0;
    tick();

    // New edge on the bit being acknowledged survives the clear.
    dev_req[5] = 1'b1;
    tick();
    dev_req[5] = 1'b0;
    to_serv(5, 8'h25, NREQ'(1) << 5);
    chk("pend5_rearm", 32'(pend_o), 32'h20);
    finish_eoi();
    to_serv(5, 8'h25, '0);
    chk("pend5_clr", 32'(pend_o), 32'd0);
    finish_eoi();
    dev_req = '0;
    tick();

    // Out-of-range channel from the encoder, then stray cpu_ack/eoi in IDLE.
    force_err = 1'b1;
    tick();
    force_err = 1'b0;
    chk("err_set", 32'(err_o), 32'd1);
    chk("irq_on_err", 32'(irq_o), 32'd0);
    cpu_ack = 1'b1; eoi = 1'b1;
    tick();
    cpu_ack = 1'b0; eoi = 1'b0;
    tick();
    chk("stray_irq", 32'(irq_o), 32'd0);
    chk("stray_vv", 32'(vec_valid), 32'd0);
    chk("stray_vec", 32'(vec_o), 32'h25);
    chk("err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of SERV.
    mask_we = 1'b1; mask_wdata = 9'h0FF;
    tick();
    mask_we = 1'b0;
    dev_req[13] = 1'b1;
    tick();
    to_serv(13, 8'h2D, '0);
    dev_req[0] = 1'b1;
    tick();
    chk("pend0_in_serv", 32'(pend_o), 32'h1);
    chk("err_before_rst", 32'(err_o), 32'd1);
    rst_n = 1'b0; dev_req = '0;
    tick();
    chk("mrst_irq", 32'(irq_o), 32'd0);
    chk("mrst_vv", 32'(vec_valid), 32'd0);
    chk("mrst_pend", 32'(pend_o), 32'd0);
    chk("mrst_en", 32'(en_o), 32'h1FF);
    chk("mrst_err", 32'(err_o), 32'd0);
    chk("mrst_vec", 32'(vec_o), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_irq", 32'(irq_o), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/irq_ack_dispatcher.md
Name: irq_ack_dispatcher

Overview:
- Device-side and CPU-side partner of the 27-channel combinational interrupt priority encoder (3 buses A/B/C × 9 channels).
- Captures device request edges into pending registers and drives them, with the channel enable mask, into the encoder.
- Takes back the encoder's bus flags and channel code, then runs the CPU interrupt handshake: irq, acknowledge, vector, end-of-interrupt.
- Acknowledges and clears the serviced device.

Parameters:
- NCH, 9, channels per bus; chan codes 0..NCH-1, channel 0 highest priority.
- NBUS, 3, number of buses; bus 0 (A) highest priority, fixed at 3 for the encoder pairing.
- VEC_BASE, 8'h20, base interrupt vector.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dev_req  in  NBUS*NCH  level requests from devices; bit b*NCH+c is bus b, channel c.
- dev_ack  out  NBUS*NCH  one-cycle acknowledge pulse to the serviced device.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NCH  new enable mask (1 = channel enabled, shared by all buses).
- pend_o  out  NBUS*NCH  pending vector to the encoder request inputs.
- en_o  out  NCH  enable mask to the encoder.
- grant_bus  in  NBUS  encoder per-bus "has request" flags.
- grant_chan  in  4  encoder winning channel index.
- irq_o  out  1  interrupt request to CPU.
- cpu_ack  in  1  CPU interrupt acknowledge (level, sampled).
- vec_o  out  8  vector, valid while vec_valid=1.
- vec_valid  out  1  vector valid.
- eoi  in  1  end-of-interrupt pulse from CPU.
- err_o  out  1  sticky: out-of-range grant_chan seen; cleared by reset only.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pend_o=0, dev_ack=0, en_o=all ones, irq_o=0, vec_o=0, vec_valid=0, err_o=0.
  - State=IDLE; previous-request register=0.
  - Applies mid-handshake too; no ack is issued for an aborted service.
- Edge capture:
  - pend[i] sets on a dev_req[i] 0→1 edge: prev_req[i]=0 and dev_req[i]=1.
  - pend[i] clears on the cycle dev_ack[i]=1.
  - Set and clear on the same bit in the same cycle: set wins; the new edge stays pending.
- Mask:
  - mask_we=1 loads en_o next cycle; any state.
  - Masking a channel never clears its pending bits.
- Encoder is combinational on pend_o/en_o; the block samples grant_bus/grant_chan directly.
- Winning bus = lowest-index set bit of grant_bus.
- States:
  - IDLE:
    - If any grant_bus bit set and grant_chan<NCH: latch cur_bus, cur_chan; go REQ.
    - If grant_bus≠0 and grant_chan≥NCH: set err_o, stay IDLE.
  - REQ:
    - irq_o=1.
    - When cpu_ack=1: compute vec_o=VEC_BASE+cur_bus*NCH+cur_chan (8-bit wrap); vec_valid=1 next cycle; go ACK.
  - ACK (1 cycle):
    - dev_ack[cur_bus*NCH+cur_chan]=1 and the pend bit clears.
    - irq_o=0; vec_valid stays 1; go SERV.
  - SERV:
    - vec_valid=1, irq_o=0, waiting for eoi.
    - eoi=1: vec_valid=0 next cycle; go IDLE.
- Latency:
  - Request edge at cycle t: pend at t+1, IDLE latch at t+1, irq_o=1 at t+2.
  - cpu_ack at t: vec_valid at t+1, dev_ack pulse at t+1.
  - eoi at t: IDLE at t+1; next irq_o no earlier than t+2.
- Latched winner holds through REQ even if the grant inputs change (preemption not supported).
- Protocol violations, ignored with no state change:
  - cpu_ack outside REQ.
  - eoi outside SERV.
  - eoi in the same cycle as ACK.
- dev_ack is exactly one bit, one cycle per serviced interrupt, never otherwise.
- With all pend bits 0 or all masked, the encoder gives grant_bus=0, so IDLE persists and irq_o=0.

Test Plan:
- Reset mid-SERV (vec_valid=1) → next cycle irq_o=0, vec_valid=0, pend_o=0, en_o=9'h1FF, no dev_ack pulse.
- dev_req[13] (bus1, chan4) rises, encoder model → irq_o high 2 cycles later; cpu_ack → vec_o=8'h2D, dev_ack[13] one-cycle pulse, pend_o[13]=0; eoi → IDLE.
- dev_req[2] and dev_req[18] rise together → bus0/chan2 serviced first (vec_o=8'h22); after eoi, bus2/chan0 serviced (vec_o=8'h32).
- mask_wdata=9'h1FB (chan2 off), dev_req[2] rises → no irq_o, pend_o[2]=1; then mask_wdata=9'h1FF → irq_o asserted, vec_o=8'h22.
- dev_req[5] toggles 0→1 in the same cycle dev_ack[5] fires → pend_o[5] stays 1; a second interrupt with vec_o=8'h25 follows.
- Encoder model forces grant_bus=3'b001, grant_chan=4'd12 → err_o=1 sticky, irq_o stays 0; stray eoi/cpu_ack in IDLE cause no change.
